reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 156 +++++++++++++++
 tb/tb_reset_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset controller.
// Synchronizes and debounces the raw active-low reset button, stretches every
// reset of the core to a fixed hold time, and optionally restarts the core a
// fixed delay after it traps. Every output is driven straight from a flop.
//
// Handshake note: this block has no valid/ready interfaces; all inputs are
// levels sampled on every rising clk edge and all outputs are levels.
//
// Parameter ranges: DEBOUNCE, HOLD and TRAP_DELAY must each be >= 1.
module reset_sequencer #(
   parameter int unsigned DEBOUNCE     = 20000,
   parameter int unsigned HOLD         = 16,
   parameter int unsigned TRAP_RESTART = 1,
   parameter int unsigned TRAP_DELAY   = 2000
) (
   input  logic       clk,
   input  logic       power_on_reset,
   input  logic       btn_n,
   input  logic       trap,
   output logic       sys_reset,
   output logic       trap_seen,
   output logic [7:0] reset_count,
   output logic [1:0] dbg_state
);

   // Counter widths are sized so each counter can hold its terminal value.
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int HW = $clog2(HOLD + 1);
   localparam int TW = $clog2(TRAP_DELAY + 1);

   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);
   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [TW-1:0] T_LAST = TW'(TRAP_DELAY - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TRAPPED = 2'd2
   } state_t;

   logic          s1;
   logic          s2;
   logic          deb;
   logic [DW-1:0] dcnt;
   state_t        state;
   logic [HW-1:0] hcnt;
   logic [TW-1:0] tcnt;

   // Saturating increment so the reset counter sticks at 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Two-flop synchronizer for the asynchronous button; idles released (1).
   always_ff @(posedge clk) begin
      if (power_on_reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
      end
   end

   // Debouncer: deb follows s2 only after s2 has differed for DEBOUNCE
   // consecutive cycles; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (power_on_reset) begin
         deb  <= 1'b1;
         dcnt <= '0;
      end else if (s2 == deb) begin
         dcnt <= '0;
      end else if (dcnt == D_LAST) begin
         deb  <= s2;
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + D_ONE;
      end
   end

   // Reset FSM: HOLD stretches the core reset, RUN watches for button and
   // trap, TRAPPED leaves the core frozen until button or restart delay.
   always_ff @(posedge clk) begin
      if (power_on_reset) begin
         state       <= ST_HOLD;
         hcnt        <= '0;
         tcnt        <= '0;
         sys_reset   <= 1'b1;
         trap_seen   <= 1'b0;
         reset_count <= 8'd0;
      end else begin
         case (state)
            ST_HOLD: begin
               sys_reset <= 1'b1;
               if (!deb) begin
                  // Button still down: the hold time starts after release.
                  hcnt <= '0;
               end else if (hcnt == H_LAST) begin
                  state     <= ST_RUN;
                  sys_reset <= 1'b0;
                  hcnt      <= '0;
               end else begin
                  hcnt <= hcnt + H_ONE;
               end
            end
            ST_RUN: begin
               sys_reset <= 1'b0;
               if (!deb) begin
                  // Button wins over a simultaneous trap, which is still noted.
                  state       <= ST_HOLD;
                  sys_reset   <= 1'b1;
                  hcnt        <= '0;
                  reset_count <= sat_inc(reset_count);
                  if (trap) begin
                     trap_seen <= 1'b1;
                  end
               end else if (trap) begin
                  state     <= ST_TRAPPED;
                  trap_seen <= 1'b1;
                  tcnt      <= '0;
               end
            end
            ST_TRAPPED: begin
               sys_reset <= 1'b0;
               if (!deb) begin
                  state       <= ST_HOLD;
                  sys_reset   <= 1'b1;
                  hcnt        <= '0;
                  reset_count <= sat_inc(reset_count);
               end else if (TRAP_RESTART != 0) begin
                  if (tcnt == T_LAST) begin
                     state       <= ST_HOLD;
                     sys_reset   <= 1'b1;
                     hcnt        <= '0;
                     reset_count <= sat_inc(reset_count);
                  end else begin
                     tcnt <= tcnt + T_ONE;
                  end
               end
            end
            default: begin
               state     <= ST_HOLD;
               sys_reset <= 1'b1;
               hcnt      <= '0;
            end
         endcase
      end
   end

   // State is exported for debug observation.
   assign dbg_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer.
// Two instances share one stimulus: "a" auto-restarts after a trap, "b" does
// not. A timeline reference model (deadlines and button history) predicts
// every output of both instances on every edge.
module tb_reset_sequencer;

   localparam int DEBOUNCE   = 4;
   localparam int HOLD       = 8;
   localparam int TRAP_DELAY = 16;

   localparam int M_HOLD = 0;
   localparam int M_RUN  = 1;
   localparam int M_TRAP = 2;

   // ---------------- clock / reset block ----------------
   logic clk;
   logic por;
   logic btn_n;
   logic trap;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       sr0, ts0, sr1, ts1;
   logic [7:0] rc0, rc1;
   logic [1:0] st0, st1;

   reset_sequencer #(
      .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .TRAP_RESTART(1), .TRAP_DELAY(TRAP_DELAY)
   ) dut_a (
      .clk(clk), .power_on_reset(por), .btn_n(btn_n), .trap(trap),
      .sys_reset(sr0), .trap_seen(ts0), .reset_count(rc0), .dbg_state(st0)
   );

   reset_sequencer #(
      .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .TRAP_RESTART(0), .TRAP_DELAY(TRAP_DELAY)
   ) dut_b (
      .clk(clk), .power_on_reset(por), .btn_n(btn_n), .trap(trap),
      .sys_reset(sr1), .trap_seen(ts1), .reset_count(rc1), .dbg_state(st1)
   );

   // ---------------- reference model ----------------
   int vectors;
   int miscompares;
   int edge_no;
   bit bq[$];          // button samples taken at past edges, newest at back
   bit m_deb;
   int m_mode[2];
   int m_rel[2];       // edge at which HOLD ends if the button stays up
   int m_rst[2];       // edge at which an auto-restart fires
   int m_cnt[2];
   bit m_sr[2];
   bit m_ts[2];

   // Button level seen 'age' edges ago; before any sample it is released.
   function automatic bit past_btn(input int age);
      if (age > bq.size()) return 1'b1;
      return bq[bq.size() - age];
   endfunction

   task automatic enter_hold(input int i);
      m_mode[i] = M_HOLD;
      m_rel[i]  = edge_no + HOLD;
      m_sr[i]   = 1'b1;
      if (m_cnt[i] < 255) m_cnt[i]++;
   endtask

   task automatic model_edge();
      bit deb_seen;
      bit all_diff;
      deb_seen = m_deb;
      if (por) begin
         bq.delete();
         m_deb = 1'b1;
         for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_HOLD;
            m_rel[i]  = edge_no + HOLD;
            m_rst[i]  = 0;
            m_cnt[i]  = 0;
            m_sr[i]   = 1'b1;
            m_ts[i]   = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
               M_HOLD: begin
                  if (!deb_seen) m_rel[i] = edge_no + HOLD;
                  else if (edge_no == m_rel[i]) begin
                     m_mode[i] = M_RUN;
                     m_sr[i]   = 1'b0;
                  end
               end
               M_RUN: begin
                  if (!deb_seen) begin
                     enter_hold(i);
                     if (trap) m_ts[i] = 1'b1;
                  end else if (trap) begin
                     m_mode[i] = M_TRAP;
                     m_rst[i]  = edge_no + TRAP_DELAY;
                     m_ts[i]   = 1'b1;
                  end
               end
               default: begin
                  if (!deb_seen || (i == 0 && edge_no == m_rst[i])) enter_hold(i);
               end
            endcase
         end
         // The synchronized level lags the pin by two edges; the debounced
         // level flips once the last DEBOUNCE synchronized samples all disagree.
         all_diff = 1'b1;
         for (int k = 2; k <= DEBOUNCE + 1; k++)
            if (past_btn(k) == m_deb) all_diff = 1'b0;
         if (all_diff) m_deb = ~m_deb;
         bq.push_back(btn_n);
         while (bq.size() > DEBOUNCE + 2) void'(bq.pop_front());
      end
      edge_no++;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic check_all();
      check("a.sys_reset",   {31'd0, sr0}, {31'd0, m_sr[0]});
      check("a.trap_seen",   {31'd0, ts0}, {31'd0, m_ts[0]});
      check("a.reset_count", {24'd0, rc0}, m_cnt[0]);
      check("b.sys_reset",   {31'd0, sr1}, {31'd0, m_sr[1]});
      check("b.trap_seen",   {31'd0, ts1}, {31'd0, m_ts[1]});
      check("b.reset_count", {24'd0, rc1}, m_cnt[1]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Steps until the chosen instance's sys_reset equals 'want' (bounded).
   task automatic wait_sr(input int which, input logic want, input int budget, output int n);
      n = 0;
      while (((which == 0) ? sr0 : sr1) !== want && n < budget) begin
         step();
         n++;
      end
      check("wait_sys_reset", {31'd0, (which == 0) ? sr0 : sr1}, {31'd0, want});
   endtask

   task automatic por_release();
      int n;
      por = 1'b1; btn_n = 1'b1; trap = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      por = 1'b0;
      wait_sr(0, 1'b0, 4 * HOLD, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random steps ----------------
   initial begin
      int n;
      int hi;
      vectors = 0; miscompares = 0; edge_no = 0; m_deb = 1'b1;
      por = 1'b1; btn_n = 1'b1; trap = 1'b0;

      // Power-on reset: values while held, then exactly HOLD cycles of reset.
      repeat (3) step();
      check("por.sys_reset",   {31'd0, sr0}, 32'd1);
      check("por.trap_seen",   {31'd0, ts0}, 32'd0);
      check("por.reset_count", {24'd0, rc0}, 32'd0);
      por = 1'b0;
      wait_sr(0, 1'b0, 100, n);
      check("por.hold_len", n, HOLD);
      check("por.count_after", {24'd0, rc0}, 32'd0);

      // Glitches shorter than DEBOUNCE never reset the core.
      repeat (5) step();
      for (int g = 0; g < 4; g++) begin
         btn_n = 1'b0;
         repeat ($urandom_range(1, DEBOUNCE - 1)) step();
         btn_n = 1'b1;
         repeat ($urandom_range(2, 6)) step();
         check("glitch.sys_reset", {31'd0, sr0}, 32'd0);
      end
      // Real press: the first step is the capture edge 0, so the rise is seen
      // on step DEBOUNCE+3 (edge DEBOUNCE+2).
      btn_n = 1'b0;
      wait_sr(0, 1'b1, 100, n);
      check("press.latency", n, DEBOUNCE + 3);
      repeat (20 - n) step();
      btn_n = 1'b1;
      wait_sr(0, 1'b0, 100, n);
      check("release.latency", n, DEBOUNCE + HOLD + 2);
      check("press.reset_count", {24'd0, rc0}, 32'd1);

      // Trap with auto-restart; extra trap pulses while trapped are ignored.
      por_release();
      repeat (3) step();
      trap = 1'b1;
      step();
      check("trap.seen_a", {31'd0, ts0}, 32'd1);
      check("trap.seen_b", {31'd0, ts1}, 32'd1);
      n = 0;
      while (sr0 !== 1'b1 && n < 100) begin
         trap = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      trap = 1'b0;
      check("trap.restart_delay", n, TRAP_DELAY);
      wait_sr(0, 1'b0, 100, n);
      check("trap.restart_hold", n, HOLD);
      check("trap.count_a", {24'd0, rc0}, 32'd1);
      check("trap.seen_sticky", {31'd0, ts0}, 32'd1);
      check("trap.halted_b", {31'd0, sr1}, 32'd0);

      // No auto-restart: stays halted until a valid press.
      por_release();
      trap = 1'b1;
      step();
      trap = 1'b0;
      hi = 0;
      for (int c = 0; c < 1000; c++) begin
         step();
         if (sr1 !== 1'b0) hi++;
      end
      check("halt.sys_reset_high", hi, 0);
      btn_n = 1'b0;
      wait_sr(1, 1'b1, 100, n);
      btn_n = 1'b1;
      wait_sr(1, 1'b0, 100, n);
      check("halt.reset_count_b", {24'd0, rc1}, 32'd1);

      // Trap in the same cycle the debounced press reaches the FSM.
      por_release();
      btn_n = 1'b0;
      repeat (DEBOUNCE + 2) step();
      trap = 1'b1;
      step();
      trap = 1'b0;
      check("both.sys_reset",   {31'd0, sr0}, 32'd1);
      check("both.trap_seen",   {31'd0, ts0}, 32'd1);
      check("both.reset_count", {24'd0, rc0}, 32'd1);
      btn_n = 1'b1;
      wait_sr(0, 1'b0, 100, n);
      repeat (2) step();
      trap = 1'b1;
      step();
      trap = 1'b0;
      repeat ($urandom_range(1, TRAP_DELAY - 3)) step();
      por = 1'b1;
      step();
      check("mid_trap_por.sys_reset",   {31'd0, sr0}, 32'd1);
      check("mid_trap_por.trap_seen",   {31'd0, ts0}, 32'd0);
      check("mid_trap_por.reset_count", {24'd0, rc0}, 32'd0);
      check("mid_trap_por.b_trap_seen", {31'd0, ts1}, 32'd0);
      por = 1'b0;

      // Random mix of presses, glitches, trap pulses and occasional resets.
      por_release();
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 19) == 0) por = 1'b1;
         btn_n = 1'b0;
         repeat ($urandom_range(1, 3 * DEBOUNCE)) begin
            trap = ($urandom_range(0, 7) == 0);
            step();
         end
         por = 1'b0;
         btn_n = 1'b1;
         repeat ($urandom_range(1, 40)) begin
            trap = ($urandom_range(0, 15) == 0);
            step();
         end
      end
      trap = 1'b0;

      // Many button resets: the counter saturates at 255.
      por_release();
      for (int r = 0; r < 300; r++) begin
         btn_n = 1'b0;
         wait_sr(0, 1'b1, 50, n);
         repeat ($urandom_range(0, 3)) step();
         btn_n = 1'b1;
         wait_sr(0, 1'b0, 60, n);
      end
      check("sat.reset_count_a", {24'd0, rc0}, 32'd255);
      check("sat.reset_count_b", {24'd0, rc1}, 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
